// File: rtl/ace_snap_loader.sv
// ace_snap_loader: streams a downloaded .ACE snapshot from hps_io into Jupiter Ace RAM.
// Expands the ED-style RLE stream (ED N B = N copies of B, ED 00 = end) into byte writes
// starting at BASE_ADDR, throttling the HPS with ioctl_wait while a run is being expanded.
// Ports:
//   clk_sys, reset        system clock, synchronous active-high reset
//   ioctl_download/index  download active flag and file index (index 0 is ignored)
//   ioctl_wr/ioctl_dout   byte strobe and data from hps_io
//   ioctl_wait            stall request back to hps_io
//   loader_reset          one-cycle core reset pulse at download start
//   loader_en             loader owns the RAM port
//   mem_addr/data/wr      RAM write port
//   done                  one-cycle pulse when the end marker is decoded
//   overflow              sticky address-overrun flag, cleared at the next download start
module ace_snap_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h2000,
    parameter logic [15:0] END_ADDR  = 16'hFFFF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        loader_reset,
    output logic        loader_en,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_wr,
    output logic        done,
    output logic        overflow
);

    localparam logic [7:0] ESC_BYTE = 8'hED;

    typedef enum logic [2:0] {
        S_IDLE, S_LIT, S_ESC, S_VAL, S_RUN, S_END
    } state_t;

    state_t      state_q, state_d;
    logic        dl_q, dl_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        wr_q, wr_d;
    logic        wait_q, wait_d;
    logic        lres_q, lres_d;
    logic        en_q, en_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        full_q, full_d;

    logic wr_ok_c, rise_c, fall_c, full_now_c;

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= S_IDLE;
            dl_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            data_q  <= 8'h00;
            wr_q    <= 1'b0;
            wait_q  <= 1'b0;
            lres_q  <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= 8'h00;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dl_q    <= dl_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            wait_q  <= wait_d;
            lres_q  <= lres_d;
            en_q    <= en_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d = state_q;
        dl_d    = ioctl_download;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        wait_d  = wait_q;
        lres_d  = 1'b0;
        en_d    = en_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        full_d  = full_q;

        // Strobes arriving while stalled are dropped
        wr_ok_c = ioctl_wr & ~wait_q;
        rise_c  = ioctl_download & ~dl_q & (ioctl_index != 8'd0);
        fall_c  = ~ioctl_download & dl_q;
        // END_ADDR already written (or being written this cycle): no room for another write
        full_now_c = full_q | (wr_q & (addr_q == END_ADDR));

        // Address advances the cycle after each visible write; saturates at END_ADDR
        if (wr_q) begin
            if (addr_q == END_ADDR) begin
                full_d = 1'b1;
            end else begin
                addr_d = addr_q + 16'd1;
            end
        end

        case (state_q)
            S_LIT: begin
                if (wr_ok_c) begin
                    if (ioctl_dout == ESC_BYTE) begin
                        state_d = S_ESC;
                    end else if (full_now_c) begin
                        ovf_d   = 1'b1;
                        state_d = S_END;
                    end else begin
                        wr_d   = 1'b1;
                        data_d = ioctl_dout;
                    end
                end
            end
            S_ESC: begin
                if (wr_ok_c) begin
                    cnt_d = ioctl_dout;
                    if (ioctl_dout == 8'd0) begin
                        state_d = S_END;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_VAL;
                    end
                end
            end
            S_VAL: begin
                if (wr_ok_c) begin
                    data_d = ioctl_dout;
                    if (full_now_c) begin
                        ovf_d   = 1'b1;
                        state_d = S_END;
                    end else begin
                        // First run write issues immediately; cnt holds writes still owed
                        wr_d    = 1'b1;
                        cnt_d   = cnt_q - 8'd1;
                        wait_d  = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (cnt_q == 8'd0) begin
                    wait_d  = 1'b0;
                    state_d = S_LIT;
                end else if (full_now_c) begin
                    ovf_d   = 1'b1;
                    wait_d  = 1'b0;
                    state_d = S_END;
                end else begin
                    wr_d  = 1'b1;
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: ;
        endcase

        if (fall_c) begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            wait_d  = 1'b0;
            wr_d    = 1'b0;
            done_d  = 1'b0;
        end

        // A new start wins over everything, including a load in progress
        if (rise_c) begin
            state_d = S_LIT;
            lres_d  = 1'b1;
            en_d    = 1'b1;
            addr_d  = BASE_ADDR;
            ovf_d   = 1'b0;
            full_d  = 1'b0;
            wait_d  = 1'b0;
            wr_d    = 1'b0;
            done_d  = 1'b0;
            cnt_d   = 8'd0;
        end
    end

    assign ioctl_wait   = wait_q;
    assign loader_reset = lres_q;
    assign loader_en    = en_q;
    assign mem_addr     = addr_q;
    assign mem_data     = data_q;
    assign mem_wr       = wr_q;
    assign done         = done_q;
    assign overflow     = ovf_q;

endmodule
